// File: rtl/capture_pkg.sv
// Shared definitions for the capture path: state encoding and default bus widths
// used by capture_sequencer, pattern_comparator and the capture RAM wrapper.
package capture_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   // ST_ prefix keeps the literals from colliding with the DONE output port.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic logic state_busy(input state_t s);
      return (s == ST_ARMED) || (s == ST_CAPTURE);
   endfunction

endpackage

// File: rtl/capture_addr_counter.sv
// Loadable up-counter for the capture window: drives the RAM write address and the
// words-written count, and flags terminal count when DEPTH words have been written.
module capture_addr_counter
   import capture_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              start,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W:0]   cnt,
   output logic              tc
);

   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH);

   // The count always runs one ahead of the address, so the next address is the count itself.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr <= '0;
         cnt  <= '0;
      end else if (start) begin
         addr <= '0;
         cnt  <= (ADDR_W+1)'(1);
      end else if (step) begin
         addr <= cnt[ADDR_W-1:0];
         cnt  <= cnt + 1'b1;
      end else if (clr) begin
         cnt  <= '0;
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/capture_sequencer.sv
// Capture window controller: once armed, writes DEPTH bus words to the capture RAM on TRIG.
// Optional armed-wait timeout is built when CAPTURE_TIMEOUT_EN is defined.
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ARM,
   input  logic              ABORT,
   input  logic              ACK,
   input  logic              TRIG,
   input  logic [DATA_W-1:0] DBUS,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              TIMEOUT,
   output logic [ADDR_W:0]   WORD_CNT
);

   if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("capture_sequencer: DEPTH out of range");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("capture_sequencer: TIMEOUT_CYCLES out of range");
   end

   state_t state;
   logic   tc;
   logic   live;
   logic   cnt_clr;
   logic   cnt_start;
   logic   cnt_step;

   assign live      = RST && !ABORT;
   assign cnt_clr   = live && (state == ST_IDLE) && ARM;
   assign cnt_start = live && (state == ST_ARMED) && TRIG;
   assign cnt_step  = live && (state == ST_CAPTURE) && !tc;

   capture_addr_counter #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_addr_counter (
      .clk   (CLK),
      .rst_n (RST),
      .clr   (cnt_clr),
      .start (cnt_start),
      .step  (cnt_step),
      .addr  (MEM_ADDR),
      .cnt   (WORD_CNT),
      .tc    (tc)
   );

`ifdef CAPTURE_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt;
   logic        timeout_q;
   assign TIMEOUT = timeout_q;
`else
   assign TIMEOUT = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= ST_IDLE;
         MEM_WE    <= 1'b0;
         MEM_WDATA <= '0;
`ifdef CAPTURE_TIMEOUT_EN
         tmo_cnt   <= '0;
         timeout_q <= 1'b0;
`endif
      end else if (ABORT) begin
         state  <= ST_IDLE;
         MEM_WE <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               MEM_WE <= 1'b0;
               if (ARM) begin
                  state <= ST_ARMED;
`ifdef CAPTURE_TIMEOUT_EN
                  tmo_cnt   <= '0;
                  timeout_q <= 1'b0;
`endif
               end
            end
            ST_ARMED: begin
               // A trigger on the expiry edge still wins and starts the capture.
               if (TRIG) begin
                  state     <= ST_CAPTURE;
                  MEM_WE    <= 1'b1;
                  MEM_WDATA <= DBUS;
               end
`ifdef CAPTURE_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  state     <= ST_IDLE;
                  timeout_q <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            ST_CAPTURE: begin
               if (tc) begin
                  state  <= ST_DONE;
                  MEM_WE <= 1'b0;
               end else begin
                  MEM_WE    <= 1'b1;
                  MEM_WDATA <= DBUS;
               end
            end
            ST_DONE: begin
               MEM_WE <= 1'b0;
               if (ACK) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state  <= ST_IDLE;
               MEM_WE <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY = state_busy(state);
   assign DONE = (state == ST_DONE);

endmodule
